// File: rtl/pwm_pkg.sv
// Shared types for the PWM modulator.
// Contents: pwm_state_t, the run/idle state of the modulator FSM.
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

endpackage

// File: rtl/pwm_modulator.sv
// PWM modulator: turns an N-bit level into a 1-bit PWM stream whose period is
// 2^N ena ticks. The requested duty is shadowed and only taken up at period
// boundaries, and a run/idle FSM lets the stream stop cleanly at a period end.
//
// Ports:
//   clk          in   system clock, all state on posedge
//   rst          in   asynchronous active-low reset
//   ena          in   tick; the period counter advances only when ena==1
//   run          in   1 = modulate, 0 = stop at the next period end
//   duty         in   requested high-time in ticks (0 .. 2^N-1)
//   out          out  PWM output
//   period_done  out  one-cycle pulse after each completed period
//   busy         out  1 while the FSM is in RUN
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped; counter parked at 0, out low, waiting for run
// RUN   | modulating; counter walks 0..MAX on ena, duty reloaded at wrap
module pwm_modulator
    import pwm_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         run,
    input  logic [N-1:0] duty,
    output logic         out,
    output logic         period_done,
    output logic         busy
);

    localparam logic [N-1:0] MAX = {N{1'b1}};

    pwm_state_t   r_state;
    pwm_state_t   w_state_nxt;
    logic [N-1:0] r_cnt;
    logic [N-1:0] w_cnt_nxt;
    logic [N-1:0] r_duty_q;
    logic [N-1:0] w_duty_nxt;
    logic         r_period_done;
    logic         w_period_done_nxt;
    logic         w_period_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_duty_q      <= '0;
            r_period_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_duty_q      <= w_duty_nxt;
            r_period_done <= w_period_done_nxt;
        end
    end

    assign w_period_end = (r_state == RUN) && ena && (r_cnt == MAX);

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_duty_nxt        = r_duty_q;
        w_period_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                // Start does not wait for ena; the first tick of the new
                // period is the cycle right after the transition.
                if (run) begin
                    w_state_nxt = RUN;
                    w_duty_nxt  = duty;
                end
            end
            RUN: begin
                if (w_period_end) begin
                    // The duty presented on the wrap edge is the one used for
                    // the whole next period; run is only honoured here so a
                    // period is never truncated.
                    w_cnt_nxt         = '0;
                    w_duty_nxt        = duty;
                    w_period_done_nxt = 1'b1;
                    if (!run) begin
                        w_state_nxt = IDLE;
                    end
                end else if (ena) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs come only from flops, so nothing on the inputs can glitch them.
    always_comb begin
        busy        = (r_state == RUN);
        out         = (r_state == RUN) && (r_cnt < r_duty_q);
        period_done = r_period_done;
    end

endmodule
